// File: rtl/audio_pkg.sv
// Shared types and constants for the audio record/playback block.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } ap_state_t;

  localparam int AMP_W               = 7;
  localparam int PWM_STEPS           = 1 << AMP_W;
  localparam int DEFAULT_DEPTH       = 131072;
  localparam int DEFAULT_PLAY_PERIOD = 2560;

endpackage

// File: rtl/audio_buffer_ram.sv
// Sample buffer: one write port, one read port with a registered (1-cycle) output.
module audio_buffer_ram
  import audio_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [AMP_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [AMP_W-1:0]  rdata
);

  logic [AMP_W-1:0] mem [DEPTH];

  // No reset on the array or read register so the tools can map this to block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/audio_record_playback.sv
// Records decimated microphone samples into a buffer and replays them as a
// 128-step PWM waveform on the mono audio output.
module audio_record_playback
  import audio_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int PLAY_PERIOD = DEFAULT_PLAY_PERIOD
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AMP_W-1:0]          amplitude,
  input  logic                      amplitude_valid,
  input  logic                      start_record,
  input  logic                      start_play,
  input  logic                      stop,
  output logic                      audio_pwm,
  output logic                      audio_en,
  output logic                      recording,
  output logic                      playing,
  output logic [$clog2(DEPTH):0]    sample_count
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int PER_W  = $clog2(PLAY_PERIOD);

  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(DEPTH - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PLAY_PERIOD - 1);
  // Period slot in which the buffer read data is valid and moves into compare.
  localparam logic [PER_W-1:0] PER_LOAD = PER_W'(1);

  ap_state_t         state, next_state;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [PER_W-1:0]  period_cnt;
  logic [AMP_W-1:0]  pwm_cnt, pwm_cnt_d;
  logic [AMP_W-1:0]  compare, compare_d;
  logic [AMP_W-1:0]  rdata;
  logic              draining;
  logic              we, load, last_sample;

  // amplitude_valid is a one-cycle strobe with no backpressure: a sample
  // offered outside RECORD, or after the buffer fills, is simply dropped.
  assign we          = (state == RECORD) && amplitude_valid;
  assign last_sample = ({1'b0, rd_ptr} == (sample_count - CNT_W'(1)));
  assign load        = (state == PLAY) && (period_cnt == PER_LOAD) && !draining;
  assign audio_en    = playing;

  audio_buffer_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(wr_ptr),
    .wdata(amplitude),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start_record) begin
          next_state = RECORD;
        end else if (start_play) begin
          next_state = PLAY;
        end
      end
      RECORD: begin
        if (stop || (we && (sample_count == FULL_M1))) begin
          next_state = IDLE;
        end
      end
      PLAY: begin
        if (stop || (sample_count == '0) || (draining && (period_cnt == PER_LOAD))) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Next-cycle PWM counter and compare value; audio_pwm is registered from
  // these so the output lines up with the cycle the compare value applies to.
  always_comb begin
    pwm_cnt_d = '0;
    compare_d = '0;
    if (state == PLAY) begin
      pwm_cnt_d = pwm_cnt + AMP_W'(1);
      compare_d = load ? rdata : compare;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_count <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      period_cnt   <= '0;
      pwm_cnt      <= '0;
      compare      <= '0;
      draining     <= 1'b0;
      audio_pwm    <= 1'b0;
      recording    <= 1'b0;
      playing      <= 1'b0;
    end else begin
      recording <= (next_state == RECORD);
      playing   <= (next_state == PLAY);
      audio_pwm <= (next_state == PLAY) && (pwm_cnt_d < compare_d);
      pwm_cnt   <= pwm_cnt_d;
      compare   <= compare_d;

      if ((state == IDLE) && (next_state == RECORD)) begin
        wr_ptr       <= '0;
        sample_count <= '0;
      end else if (we) begin
        sample_count <= sample_count + CNT_W'(1);
        if (sample_count != FULL_M1) begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
        end
      end

      // Outside PLAY the read side is held at its entry values.
      if (state != PLAY) begin
        rd_ptr     <= '0;
        period_cnt <= '0;
        draining   <= 1'b0;
      end else if (period_cnt == PER_LAST) begin
        period_cnt <= '0;
        if (last_sample) begin
          draining <= 1'b1;
        end else begin
          rd_ptr <= rd_ptr + ADDR_W'(1);
        end
      end else begin
        period_cnt <= period_cnt + PER_W'(1);
      end
    end
  end

endmodule
